// File: rtl/cdb_pkg.sv
// Shared CDB constants: field widths, lane layout offsets and source indices.
// Pure declarations: no latency and no flow control of its own.
package cdb_pkg;

    localparam int TAG_W         = 4;
    localparam int DATA_W        = 16;
    localparam int CDB_W         = 1 + TAG_W + DATA_W;
    localparam int CDB_VALID_BIT = CDB_W - 1;
    localparam int CDB_TAG_LSB   = DATA_W;
    localparam int CDB_DATA_LSB  = 0;

    localparam int SRC_INT = 0;
    localparam int SRC_MUL = 1;
    localparam int SRC_LS  = 2;

endpackage

// File: rtl/cdb_src_queue.sv
// Per-source result FIFO; a push lands at the clock edge and the head is visible one cycle later.
// When full, a push is accepted only if the head is popped in the same cycle; otherwise it is ignored.
module cdb_src_queue
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = TAG_W + DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full queue can still take a push.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok)
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop_ok)
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok)
            count_d = count_q + CNT_W'(1);
        else if (pop_ok && !push_ok)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter over per-source queues; a stored entry reaches the registered CDB one edge after it is queued.
// src_full tells issue logic to stop; a result arriving at a full, unpopped queue is dropped and flags sticky overflow.
module cdb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 2,
    parameter int TAG_W   = cdb_pkg::TAG_W,
    parameter int DATA_W  = cdb_pkg::DATA_W
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_SRC*(1+TAG_W+DATA_W)-1:0]         src_result,
    output logic [NUM_SRC-1:0]                          src_full,
    output logic                                        cdb_valid,
    output logic [TAG_W-1:0]                            cdb_tag,
    output logic [DATA_W-1:0]                           cdb_data,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] cdb_src,
    output logic                                        overflow
);

    import cdb_pkg::*;

    localparam int ENT_W  = TAG_W + DATA_W;
    localparam int LANE_W = 1 + ENT_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] src_vld;
    logic [NUM_SRC-1:0] pop;
    logic [ENT_W-1:0]   src_ent [NUM_SRC];
    logic [ENT_W-1:0]   head    [NUM_SRC];
    logic [CNT_W-1:0]   cnt     [NUM_SRC];

    logic               grant_vld;
    logic [SRC_W-1:0]   grant_src;
    logic [ENT_W-1:0]   grant_ent;
    int                 idx;

    logic               cdb_valid_q;
    logic [TAG_W-1:0]   cdb_tag_q;
    logic [DATA_W-1:0]  cdb_data_q;
    logic [SRC_W-1:0]   cdb_src_q;
    logic [SRC_W-1:0]   last_grant_q;
    logic               overflow_q, overflow_d;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign src_vld[g] = src_result[g*LANE_W + LANE_W - 1];
        assign src_ent[g] = src_result[g*LANE_W +: ENT_W];

        cdb_src_queue #(
            .DEPTH (DEPTH),
            .W     (ENT_W)
        ) u_queue (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (src_vld[g]),
            .pop_i   (pop[g]),
            .data_i  (src_ent[g]),
            .head_o  (head[g]),
            .count_o (cnt[g]),
            .full_o  (src_full[g])
        );
    end

    // Search starts just after the last winner; only already-stored entries compete.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = '0;
        grant_ent = '0;
        pop       = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_SRC;
            if (!grant_vld && (cnt[idx] != '0)) begin
                grant_vld = 1'b1;
                grant_src = SRC_W'(idx);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_vld && (grant_src == SRC_W'(i))) begin
                pop[i]    = 1'b1;
                grant_ent = head[i];
            end
        end
    end

    assign overflow_d = overflow_q | (|(src_vld & src_full & ~pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_data_q   <= '0;
            cdb_src_q    <= '0;
            last_grant_q <= SRC_W'(NUM_SRC - 1);
            overflow_q   <= 1'b0;
        end else begin
            cdb_valid_q <= grant_vld;
            overflow_q  <= overflow_d;
            if (grant_vld) begin
                cdb_tag_q    <= grant_ent[DATA_W +: TAG_W];
                cdb_data_q   <= grant_ent[0 +: DATA_W];
                cdb_src_q    <= grant_src;
                last_grant_q <= grant_src;
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;
    assign overflow  = overflow_q;

endmodule
